// File: rtl/priority_resolver_isr.sv
// Interrupt priority resolver with In-Service Register, two-pulse INTA
// acknowledge sequencing, vector generation and OCW2 EOI/rotation handling.
module priority_resolver_isr #(
    parameter int NUM_IR = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NUM_IR-1:0] irr,
    input  logic [NUM_IR-1:0] imr,
    input  logic              aeoi,
    input  logic [4:0]        vector_base,
    input  logic              inta_n,
    input  logic              ocw2_wr,
    input  logic [7:0]        ocw2,
    output logic              int_out,
    output logic              freeze,
    output logic [NUM_IR-1:0] clear_interrupt_request,
    output logic [NUM_IR-1:0] isr,
    output logic [7:0]        vector_out,
    output logic              vector_out_en
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INT,
        S_ACK1,
        S_WAIT2,
        S_ACK2
    } state_t;

    // {found, level} of the highest-priority set bit; priority starts after lp
    function automatic logic [3:0] first_set(
        input logic [7:0] v,
        input logic [2:0] lp
    );
        logic [3:0] r;
        logic [2:0] idx;
        r = 4'b0;
        for (int k = 7; k >= 0; k--) begin
            idx = lp + 3'd1 + 3'(k);
            if (v[idx]) r = {1'b1, idx};
        end
        return r;
    endfunction

    // 0 = highest priority, 7 = lowest
    function automatic logic [2:0] rank(
        input logic [2:0] lvl_i,
        input logic [2:0] lp
    );
        return lvl_i - lp - 3'd1;
    endfunction

    function automatic logic [7:0] onehot(input logic [2:0] l);
        return 8'h01 << l;
    endfunction

    state_t      state;
    state_t      state_d;
    logic        inta_prev;
    logic [2:0]  lowest_pri;
    logic        rotate_in_aeoi;
    logic [2:0]  lvl;
    logic        spurious;

    logic [7:0]  req;
    logic [3:0]  win_f;
    logic [3:0]  top_f;
    logic [2:0]  win;
    logic [2:0]  top_isr;
    logic        req_any;
    logic        isr_any;
    logic        pending;
    logic        fall;
    logic        rise;

    logic [7:0]  isr_eoi;
    logic [2:0]  lp_ocw;
    logic        rot_ocw;
    logic [2:0]  ocw_l;

    logic        int_out_d;
    logic        freeze_d;
    logic [7:0]  clr_d;
    logic [7:0]  vec_d;
    logic        vec_en_d;
    logic [2:0]  lvl_d;
    logic        spur_d;
    logic [7:0]  isr_set;
    logic [7:0]  isr_clr;
    logic        aeoi_rot;
    logic [7:0]  isr_d;
    logic [2:0]  lp_d;

    assign req     = irr & ~imr;
    assign win_f   = first_set(req, lowest_pri);
    assign top_f   = first_set(isr, lowest_pri);
    assign win     = win_f[2:0];
    assign req_any = win_f[3];
    assign top_isr = top_f[2:0];
    assign isr_any = top_f[3];

    assign pending = req_any &&
                     (!isr_any ||
                      rank(win, lowest_pri) < rank(top_isr, lowest_pri));

    assign fall  = inta_prev & ~inta_n;
    assign rise  = ~inta_prev & inta_n;
    assign ocw_l = ocw2[2:0];

    always_comb begin
        isr_eoi = isr;
        lp_ocw  = lowest_pri;
        rot_ocw = rotate_in_aeoi;
        if (ocw2_wr) begin
            unique case (ocw2[7:5])
                3'b001: begin
                    if (isr_any) isr_eoi[top_isr] = 1'b0;
                end
                3'b011: isr_eoi[ocw_l] = 1'b0;
                3'b101: begin
                    if (isr_any) begin
                        isr_eoi[top_isr] = 1'b0;
                        lp_ocw = top_isr;
                    end
                end
                3'b111: begin
                    isr_eoi[ocw_l] = 1'b0;
                    lp_ocw = ocw_l;
                end
                3'b100: rot_ocw = 1'b1;
                3'b000: rot_ocw = 1'b0;
                3'b110: lp_ocw = ocw_l;
                3'b010: ;
                default: ;
            endcase
        end
    end

    always_comb begin
        state_d   = state;
        int_out_d = int_out;
        freeze_d  = freeze;
        clr_d     = 8'h00;
        vec_d     = vector_out;
        vec_en_d  = vector_out_en;
        lvl_d     = lvl;
        spur_d    = spurious;
        isr_set   = 8'h00;
        isr_clr   = 8'h00;
        aeoi_rot  = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (pending) begin
                    state_d   = S_INT;
                    int_out_d = 1'b1;
                end
            end
            S_INT: begin
                if (fall) begin
                    state_d   = S_ACK1;
                    int_out_d = 1'b0;
                    freeze_d  = 1'b1;
                    if (req_any) begin
                        lvl_d   = win;
                        spur_d  = 1'b0;
                        isr_set = onehot(win);
                        clr_d   = onehot(win);
                    end else begin
                        lvl_d  = 3'd7;
                        spur_d = 1'b1;
                    end
                end else if (!pending) begin
                    state_d   = S_IDLE;
                    int_out_d = 1'b0;
                end
            end
            S_ACK1: begin
                if (rise) state_d = S_WAIT2;
            end
            S_WAIT2: begin
                if (fall) begin
                    state_d  = S_ACK2;
                    vec_d    = {vector_base, lvl};
                    vec_en_d = 1'b1;
                end
            end
            S_ACK2: begin
                if (rise) begin
                    state_d  = S_IDLE;
                    vec_en_d = 1'b0;
                    freeze_d = 1'b0;
                    if (aeoi && !spurious) begin
                        isr_clr  = onehot(lvl);
                        aeoi_rot = rotate_in_aeoi;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // EOI clears land before the acknowledge set; AEOI rotation beats OCW2
    assign isr_d = (isr_eoi & ~isr_clr) | isr_set;
    assign lp_d  = aeoi_rot ? lvl : lp_ocw;

    always_ff @(posedge clk) begin
        if (reset) begin
            state                   <= S_IDLE;
            inta_prev               <= 1'b1;
            lowest_pri              <= 3'd7;
            rotate_in_aeoi          <= 1'b0;
            lvl                     <= 3'd0;
            spurious                <= 1'b0;
            int_out                 <= 1'b0;
            freeze                  <= 1'b0;
            clear_interrupt_request <= 8'h00;
            isr                     <= 8'h00;
            vector_out              <= 8'h00;
            vector_out_en           <= 1'b0;
        end else begin
            state                   <= state_d;
            inta_prev               <= inta_n;
            lowest_pri              <= lp_d;
            rotate_in_aeoi          <= rot_ocw;
            lvl                     <= lvl_d;
            spurious                <= spur_d;
            int_out                 <= int_out_d;
            freeze                  <= freeze_d;
            clear_interrupt_request <= clr_d;
            isr                     <= isr_d;
            vector_out              <= vec_d;
            vector_out_en           <= vec_en_d;
        end
    end

endmodule

// File: tb/tb_priority_resolver_isr.sv
// Bench for priority_resolver_isr: directed scenarios plus randomized
// traffic against a level-priority reference model.
module tb_priority_resolver_isr;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] irr;
    logic [7:0] imr;
    logic       aeoi;
    logic [4:0] vector_base;
    logic       inta_n;
    logic       ocw2_wr;
    logic [7:0] ocw2;
    logic       int_out;
    logic       freeze;
    logic [7:0] clr_req;
    logic [7:0] isr;
    logic [7:0] vector_out;
    logic       vector_out_en;

    int checks = 0;
    int errors = 0;

    logic [7:0] isr_m;
    int         lp_m;
    bit         rot_m;

    priority_resolver_isr #(.NUM_IR(8)) dut (
        .clk(clk),
        .reset(reset),
        .irr(irr),
        .imr(imr),
        .aeoi(aeoi),
        .vector_base(vector_base),
        .inta_n(inta_n),
        .ocw2_wr(ocw2_wr),
        .ocw2(ocw2),
        .int_out(int_out),
        .freeze(freeze),
        .clear_interrupt_request(clr_req),
        .isr(isr),
        .vector_out(vector_out),
        .vector_out_en(vector_out_en)
    );

    always #5 clk = ~clk;

    function automatic int pos(int l);
        return (l - lp_m - 1 + 16) % 8;
    endfunction

    function automatic int first_of(logic [7:0] v);
        int best;
        best = -1;
        for (int l = 0; l < 8; l++)
            if (v[l] && (best < 0 || pos(l) < pos(best))) best = l;
        return best;
    endfunction

    function automatic bit pending_m();
        int w;
        int t;
        w = first_of(irr & ~imr);
        t = first_of(isr_m);
        if (w < 0) return 1'b0;
        if (t < 0) return 1'b1;
        return pos(w) < pos(t);
    endfunction

    task automatic model_reset();
        isr_m = 8'h00;
        lp_m  = 7;
        rot_m = 1'b0;
    endtask

    task automatic model_ocw(input logic [7:0] v);
        int t;
        int l;
        t = first_of(isr_m);
        l = int'(v[2:0]);
        case (v[7:5])
            3'd1: if (t >= 0) isr_m[t] = 1'b0;
            3'd3: isr_m[l] = 1'b0;
            3'd5: if (t >= 0) begin isr_m[t] = 1'b0; lp_m = t; end
            3'd7: begin isr_m[l] = 1'b0; lp_m = l; end
            3'd4: rot_m = 1'b1;
            3'd0: rot_m = 1'b0;
            3'd6: lp_m = l;
            default: ;
        endcase
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_ocw(input logic [7:0] v);
        ocw2    = v;
        ocw2_wr = 1'b1;
        model_ocw(v);
        tick();
        ocw2_wr = 1'b0;
    endtask

    task automatic settle(input string nm);
        bit exp_int;
        tick();
        tick();
        exp_int = pending_m();
        checks++;
        if (int_out !== exp_int) begin
            errors++;
            $display("FAIL %s int_out: got %b want %b", nm, int_out, exp_int);
        end
        checks++;
        if (isr !== isr_m) begin
            errors++;
            $display("FAIL %s isr: got %h want %h", nm, isr, isr_m);
        end
    endtask

    task automatic full_ack(input bit fw, input logic [7:0] fo,
                            input bit rw, input logic [7:0] ro);
        int         w;
        int         lv;
        bit         spur;
        bit         rot_before;
        logic [7:0] exp_clr;
        logic [7:0] exp_vec;
        checks++;
        if (int_out !== 1'b1) begin
            errors++;
            $display("FAIL ack_pre int_out: got %b want 1", int_out);
        end
        w = first_of(irr & ~imr);
        spur    = (w < 0);
        lv      = spur ? 7 : w;
        exp_clr = spur ? 8'h00 : (8'h01 << w);
        if (fw) model_ocw(fo);
        if (!spur) isr_m[lv] = 1'b1;
        inta_n  = 1'b0;
        ocw2_wr = fw;
        ocw2    = fo;
        tick();
        ocw2_wr = 1'b0;
        checks++;
        if (clr_req !== exp_clr || freeze !== 1'b1 || int_out !== 1'b0) begin
            errors++;
            $display("FAIL ack1 clr/frz/int: got %h/%b/%b want %h/1/0",
                     clr_req, freeze, int_out, exp_clr);
        end
        checks++;
        if (isr !== isr_m) begin
            errors++;
            $display("FAIL ack1 isr: got %h want %h", isr, isr_m);
        end
        irr = irr & ~exp_clr;
        tick();
        checks++;
        if (clr_req !== 8'h00) begin
            errors++;
            $display("FAIL clr_pulse_len: got %h want 00", clr_req);
        end
        inta_n = 1'b1;
        tick();
        checks++;
        if (freeze !== 1'b1 || vector_out_en !== 1'b0) begin
            errors++;
            $display("FAIL wait2 frz/en: got %b/%b want 1/0",
                     freeze, vector_out_en);
        end
        inta_n  = 1'b0;
        exp_vec = {vector_base, 3'(lv)};
        tick();
        checks++;
        if (vector_out_en !== 1'b1 || vector_out !== exp_vec) begin
            errors++;
            $display("FAIL ack2 vector: got %b/%h want 1/%h",
                     vector_out_en, vector_out, exp_vec);
        end
        rot_before = rot_m;
        inta_n  = 1'b1;
        ocw2_wr = rw;
        ocw2    = ro;
        if (rw) model_ocw(ro);
        if (aeoi && !spur) begin
            isr_m[lv] = 1'b0;
            if (rot_before) lp_m = lv;
        end
        tick();
        ocw2_wr = 1'b0;
        checks++;
        if (vector_out_en !== 1'b0 || freeze !== 1'b0 || isr !== isr_m) begin
            errors++;
            $display("FAIL ack_end en/frz/isr: got %b/%b/%h want 0/0/%h",
                     vector_out_en, freeze, isr, isr_m);
        end
    endtask

    task automatic test_reset();
        reset       = 1'b1;
        irr         = 8'h00;
        imr         = 8'h00;
        aeoi        = 1'b0;
        vector_base = 5'h11;
        inta_n      = 1'b1;
        ocw2_wr     = 1'b0;
        ocw2        = 8'h00;
        tick();
        tick();
        reset = 1'b0;
        model_reset();
        checks++;
        if ({int_out, freeze, clr_req, isr, vector_out, vector_out_en} !== 27'd0) begin
            errors++;
            $display("FAIL reset outputs: got %b%b %h %h %h %b want all zero",
                     int_out, freeze, clr_req, isr, vector_out, vector_out_en);
        end
    endtask

    task automatic test_nested_eoi();
        irr = 8'h0C;
        settle("t1_req");
        full_ack(0, 8'h00, 0, 8'h00);
        settle("t1_ir3_blocked");
        do_ocw(8'h20);
        settle("t1_after_eoi");
        full_ack(0, 8'h00, 0, 8'h00);
        do_ocw(8'h20);
        irr = 8'h10;
        settle("t2_ir4");
        full_ack(0, 8'h00, 0, 8'h00);
        irr = 8'h02;
        settle("t2_nested");
        full_ack(0, 8'h00, 0, 8'h00);
        checks++;
        if (isr !== 8'h12) begin
            errors++;
            $display("FAIL t2_isr: got %h want 12", isr);
        end
        do_ocw(8'h20);
        do_ocw(8'h20);
        settle("t2_drained");
    endtask

    task automatic test_aeoi_rotate();
        aeoi = 1'b1;
        do_ocw(8'h80);
        irr = 8'h01;
        settle("t3_ir0");
        full_ack(0, 8'h00, 0, 8'h00);
        checks++;
        if (isr !== 8'h00) begin
            errors++;
            $display("FAIL t3_aeoi_isr: got %h want 00", isr);
        end
        irr = 8'h81;
        settle("t3_ir7");
        checks++;
        if (first_of(irr) !== 7) begin
            errors++;
            $display("FAIL t3_model_win: got %0d want 7", first_of(irr));
        end
        full_ack(0, 8'h00, 1, 8'hC3);
        do_ocw(8'h00);
        aeoi = 1'b0;
        irr  = 8'h00;
        settle("t3_done");
    endtask

    task automatic test_drop_and_spurious();
        irr = 8'h01;
        settle("t4_req");
        irr = 8'h00;
        tick();
        checks++;
        if (int_out !== 1'b0) begin
            errors++;
            $display("FAIL t4_drop: got %b want 0", int_out);
        end
        irr = 8'h01;
        settle("t4_req2");
        irr = 8'h00;
        full_ack(0, 8'h00, 0, 8'h00);
        settle("t4_spurious_after");
    endtask

    task automatic test_specific_rotate();
        irr = 8'h20;
        settle("t5_ir5");
        full_ack(0, 8'h00, 0, 8'h00);
        do_ocw(8'hE5);
        irr = 8'hC1;
        settle("t5_ir6_top");
        full_ack(0, 8'h00, 0, 8'h00);
        do_ocw(8'h20);
        irr = 8'h10;
        do_ocw(8'h20);
        settle("t5_ir4");
        full_ack(1, 8'h20, 0, 8'h00);
        irr = 8'h02;
        settle("t5_ir1");
        full_ack(1, 8'h61, 0, 8'h00);
        do_ocw(8'h20);
        do_ocw(8'h20);
        do_ocw(8'hC7);
        irr = 8'h00;
        settle("t5_done");
    endtask

    task automatic test_reset_mid();
        irr = 8'h04;
        settle("t6_req");
        inta_n = 1'b0;
        tick();
        inta_n = 1'b1;
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        model_reset();
        checks++;
        if (freeze !== 1'b0 || isr !== 8'h00 ||
            vector_out_en !== 1'b0 || int_out !== 1'b0) begin
            errors++;
            $display("FAIL t6_reset: frz %b isr %h en %b int %b want 0",
                     freeze, isr, vector_out_en, int_out);
        end
        irr = 8'h00;
        settle("t6_after");
    endtask

    task automatic test_random();
        logic [7:0] fo;
        logic [7:0] ro;
        for (int i = 0; i < 80; i++) begin
            vector_base = 5'($urandom);
            aeoi        = 1'($urandom_range(0, 1));
            irr         = 8'($urandom);
            imr         = 8'($urandom) & 8'($urandom);
            if ($urandom_range(0, 2) == 0)
                do_ocw({3'($urandom_range(0, 7)), 2'b00, 3'($urandom_range(0, 7))});
            settle("rand_int");
            if (pending_m()) begin
                fo = {3'($urandom_range(0, 7)), 2'b00, 3'($urandom_range(0, 7))};
                ro = {3'($urandom_range(0, 7)), 2'b00, 3'($urandom_range(0, 7))};
                full_ack($urandom_range(0, 3) == 0, fo,
                         $urandom_range(0, 3) == 0, ro);
            end
            if ($urandom_range(0, 1) == 0) do_ocw(8'h20);
        end
        imr = 8'h00;
    endtask

    initial begin
        test_reset();
        test_nested_eoi();
        test_aeoi_rotate();
        test_drop_and_spurious();
        test_specific_rotate();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
